instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Program-counter and fetch stage feeding the instruction memory and the decoder.
//  - Drives the word address into instruction memory and captures the returned word.
//  - Hands the captured instruction, with its PC, to decode under a valid/stall handshake.
//  - Accepts branch/jump redirects from execute and a halt request.
// PARAMETERS
//  ADDR_W    32   width of imem_addr / PC (word address, not byte address)
//  DATA_W    32   instruction width
//  MEM_SIZE  32   instruction words; PC wraps modulo MEM_SIZE (power of 2)
//  RESET_PC  0    PC value loaded on reset
// PORTS
//  clka           in   1       clock, all state updates on rising edge
//  rst_n          in   1       asynchronous active-low reset
//  imem_addr      out  ADDR_W  word address to instruction memory (= pc, combinational)
//  imem_data      in   DATA_W  instruction word at imem_addr, valid within same cycle
//  stall          in   1       decode not ready; hold fetch state and outputs
//  redirect_valid in   1       taken branch/jump this cycle
//  redirect_pc    in   ADDR_W  target word address for redirect
//  halt           in   1       stop fetching (halt instruction retired)
//  instr_valid    out  1       instr/instr_pc hold a live instruction
//  instr          out  DATA_W  fetched instruction register
//  instr_pc       out  ADDR_W  word address instr was fetched from
//  pc_next_seq    out  ADDR_W  instr_pc+1 mod MEM_SIZE (link value for jal)
//  halted         out  1       FSM in S_HALT
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, instr=0, instr_pc=0, pc_next_seq=0,
//   instr_valid=0, halted=0, state=S_BOOT. Reset mid-operation discards all state.
//  FSM: S_BOOT -> S_RUN (next edge, unconditionally; no fetch captured in S_BOOT)
//       S_RUN  -> S_HALT when halt=1; S_HALT exits only via reset.
//  S_RUN per edge, priority halt > redirect_valid > stall > normal:
//   - halt:     instr_valid<=0, pc holds, state<=S_HALT.
//   - redirect: pc<=redirect_pc mod MEM_SIZE, instr_valid<=0 (flush wrong-path
//               word); instr/instr_pc hold. Applies even if stall=1.
//   - stall:    pc, instr, instr_pc, instr_valid, pc_next_seq all hold.
//   - normal:   instr<=imem_data, instr_pc<=pc, pc_next_seq<=(pc+1) mod MEM_SIZE,
//               instr_valid<=1, pc<=(pc+1) mod MEM_SIZE.
//  Latency: word at address A appears on instr one edge after pc==A with no stall.
//  Throughput: one instruction per cycle when stall=0.
//  Wrap: pc==MEM_SIZE-1 advances to 0; pc_next_seq wraps identically.
//  Out-of-range redirect_pc: upper bits discarded (low log2(MEM_SIZE) bits kept).
//  S_BOOT/S_HALT: imem_addr still = pc; redirect and stall ignored; instr_valid=0.
//  Redirect target fetched next edge: instr_valid rises 2 edges after redirect.
// TESTING
//  1 Reset release, imem[i]=i+0x100, stall=0: edge1 S_BOOT->S_RUN, then
//    instr=0x100,0x101,... with instr_pc=0,1,...; instr_valid=1 from 2nd edge.
//  2 Stall=1 for 3 cycles at instr_pc=4: instr=0x104, pc=5 held 3 cycles;
//    release -> instr=0x105 next edge, no skip/duplicate.
//  3 redirect_valid=1, redirect_pc=20 while pc=7: next edge instr_valid=0, pc=20;
//    following edge instr=0x114, instr_pc=20, pc_next_seq=21.
//  4 redirect and stall both 1: redirect wins, pc=redirect target, instr_valid=0.
//  5 Run to pc=31: next fetch instr_pc=31, pc_next_seq=0, pc=0; redirect_pc=35 -> pc=3.
//  6 halt=1 at pc=9: instr_valid=0, halted=1, pc=9 held for 10 cycles despite
//    redirect; assert rst_n=0 mid-halt -> all outputs return to reset values at once.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives instruction memory, and registers the returned
// word with its PC for decode under a valid/stall handshake.
module instruction_fetch #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_SIZE = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clka,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              halted
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_SIZE - 1);
  localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [DATA_W-1:0] instr_nxt;
  logic [ADDR_W-1:0] instr_pc_nxt;
  logic [ADDR_W-1:0] pc_next_seq_nxt;
  logic              instr_valid_nxt;
  logic [ADDR_W-1:0] pc_inc;

  // MEM_SIZE is a power of two, so modulo reduces to masking the low bits.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
    return a & ADDR_MASK;
  endfunction

  assign pc_inc    = wrap_addr(pc + ADDR_W'(1));
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= PC_INIT;
      instr       <= '0;
      instr_pc    <= '0;
      pc_next_seq <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      instr_pc    <= instr_pc_nxt;
      pc_next_seq <= pc_next_seq_nxt;
      instr_valid <= instr_valid_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    instr_nxt       = instr;
    instr_pc_nxt    = instr_pc;
    pc_next_seq_nxt = pc_next_seq;
    instr_valid_nxt = instr_valid;
    case (state)
      S_BOOT: begin
        state_nxt       = S_RUN;
        instr_valid_nxt = 1'b0;
      end
      S_RUN: begin
        // Priority: halt > redirect > stall > sequential fetch.
        if (halt) begin
          state_nxt       = S_HALT;
          instr_valid_nxt = 1'b0;
        end else if (redirect_valid) begin
          pc_nxt          = wrap_addr(redirect_pc);
          instr_valid_nxt = 1'b0;
        end else if (!stall) begin
          instr_nxt       = imem_data;
          instr_pc_nxt    = pc;
          pc_next_seq_nxt = pc_inc;
          instr_valid_nxt = 1'b1;
          pc_nxt          = pc_inc;
        end
      end
      S_HALT: begin
        instr_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt       = S_BOOT;
        instr_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a reference model pushes expected fetches
// into a queue as stimulus is applied; they are popped when the DUT reports them.
module tb_instruction_fetch;

  logic        clka = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_next_seq;
  logic        halted;

  instruction_fetch #(
    .ADDR_W(32), .DATA_W(32), .MEM_SIZE(32), .RESET_PC(0)
  ) dut (
    .clka(clka), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .pc_next_seq(pc_next_seq), .halted(halted)
  );

  always #5 clka = ~clka;

  logic [31:0] imem [32];
  assign imem_data = imem[imem_addr[4:0]];

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] p;
    logic [31:0] n;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  typedef enum int {M_BOOT, M_RUN, M_HALT} mstate_t;
  mstate_t     mstate;
  logic [31:0] mpc;
  logic        mvalid;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mstate = M_BOOT;
    mpc    = 32'd0;
    mvalid = 1'b0;
    cur    = '0;
    q.delete();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".imem_addr"},   imem_addr,   mpc);
    chk({tag, ".instr_valid"}, instr_valid, mvalid);
    chk({tag, ".halted"},      halted,      mstate == M_HALT);
    chk({tag, ".instr"},       instr,       cur.i);
    chk({tag, ".instr_pc"},    instr_pc,    cur.p);
    chk({tag, ".pc_next_seq"}, pc_next_seq, cur.n);
  endtask

  // One clock edge with the given inputs; model advances, then outputs are compared.
  task automatic cycle(input string tag, input logic h, input logic r,
                       input logic [31:0] rpc, input logic s);
    logic fetched;
    fetched        = 1'b0;
    halt           = h;
    redirect_valid = r;
    redirect_pc    = rpc;
    stall          = s;
    case (mstate)
      M_BOOT: begin mstate = M_RUN; mvalid = 1'b0; end
      M_RUN: begin
        if (h) begin
          mstate = M_HALT; mvalid = 1'b0;
        end else if (r) begin
          mpc = rpc % 32; mvalid = 1'b0;
        end else if (!s) begin
          q.push_back('{i: mpc + 32'h100, p: mpc, n: (mpc + 1) % 32});
          mpc = (mpc + 1) % 32; mvalid = 1'b1; fetched = 1'b1;
        end
      end
      default: mvalid = 1'b0;
    endcase
    @(posedge clka);
    #1;
    if (fetched) cur = q.pop_front();
    check_outputs(tag);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) imem[k] = 32'h100 + k;
    rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    model_reset();
    repeat (2) @(posedge clka);
    #1;
    check_outputs("reset");
    @(negedge clka);
    rst_n = 1'b1;
    @(posedge clka);
    #1;
    // The release edge above fell while rst_n was already high: BOOT->RUN happened.
    mstate = M_RUN;
    check_outputs("boot");

    // Sequential fetch of words 0..4.
    for (int k = 0; k < 5; k++) cycle("seq", 0, 0, 0, 0);
    chk("seq_instr4", instr, 32'h104);

    // Stall three cycles holding instr_pc=4, pc=5.
    for (int k = 0; k < 3; k++) begin
      cycle("stall", 0, 0, 0, 1);
      chk("stall_pc", imem_addr, 32'd5);
      chk("stall_instr", instr, 32'h104);
    end
    cycle("unstall", 0, 0, 0, 0);
    chk("unstall_instr", instr, 32'h105);
    cycle("seq6", 0, 0, 0, 0);
    chk("pc_before_redirect", imem_addr, 32'd7);

    // Redirect to 20 while pc=7.
    cycle("redir", 0, 1, 32'd20, 0);
    chk("redir_valid", instr_valid, 1'b0);
    chk("redir_pc", imem_addr, 32'd20);
    cycle("redir_fetch", 0, 0, 0, 0);
    chk("redir_instr", instr, 32'h114);
    chk("redir_instr_pc", instr_pc, 32'd20);
    chk("redir_link", pc_next_seq, 32'd21);

    // Redirect wins over stall.
    cycle("redir_stall", 0, 1, 32'd10, 1);
    chk("rs_pc", imem_addr, 32'd10);
    chk("rs_valid", instr_valid, 1'b0);

    // Run up to the top of memory and wrap.
    for (int k = 10; k <= 31; k++) cycle("run", 0, 0, 0, 0);
    chk("wrap_instr_pc", instr_pc, 32'd31);
    chk("wrap_link", pc_next_seq, 32'd0);
    chk("wrap_pc", imem_addr, 32'd0);
    cycle("redir35", 0, 1, 32'd35, 0);
    chk("redir35_pc", imem_addr, 32'd3);

    // Advance to pc=9, then halt.
    for (int k = 3; k < 9; k++) cycle("to9", 0, 0, 0, 0);
    chk("pre_halt_pc", imem_addr, 32'd9);
    cycle("halt", 1, 0, 0, 0);
    chk("halt_halted", halted, 1'b1);
    chk("halt_valid", instr_valid, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle("halted", k[0], 1, 32'd25, 0);
      chk("halt_pc_hold", imem_addr, 32'd9);
    end

    // Asynchronous reset in the middle of a cycle.
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst_halted", halted, 1'b0);
    @(negedge clka);
    rst_n = 1'b1;
    cycle("reboot", 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle("restart", 0, 0, 0, 0);
    chk("restart_instr", instr, 32'h102);
    chk("sb_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
